// File: rtl/sm83_bus_pkg.sv
// Shared types and T-phase strobe windows for the SM83 memory-bus controller.
// Phase vectors are packed as {t4, t3, t2, t1}.
package sm83_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } bus_state_t;

    localparam logic [3:0] RD_STB_WIN = 4'b0111;  // rd_n low t1..t3
    localparam logic [3:0] WR_STB_WIN = 4'b0110;  // wr_n low t2..t3
    localparam logic [3:0] WR_OE_WIN  = 4'b1110;  // dout driven t2..t4

    function automatic logic in_window(input logic [3:0] ph, input logic [3:0] win);
        return |(ph & win);
    endfunction

endpackage

// File: rtl/sm83_bus_wait_ctr.sv
// Saturating wait-state counter: counts stalled clocks and flags when the limit is reached.
module sm83_bus_wait_ctr #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic at_max
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != MAX_V)) begin
            count <= count + W'(1);
        end
    end

    assign at_max = (count == MAX_V);

endmodule

// File: rtl/sm83_bus_ctrl.sv
// SM83 memory-bus responder: turns sequencer T-phases and decoder requests into bus cycles.
// Optional wait-state support (mem_ready/stall/timeout) is enabled by defining SM83_BUS_WAIT_EN.
//
//   state | meaning
//   IDLE  | no access this M-cycle, strobes inactive
//   RD    | read access: rd_n low t1..t3, din captured at end of t3
//   WR    | write access: wr_n low t2..t3, dout driven t2..t4
module sm83_bus_ctrl
    import sm83_bus_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 8
`ifdef SM83_BUS_WAIT_EN
    ,
    parameter int WAIT_MAX = 15
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          t1,
    input  logic          t2,
    input  logic          t3,
    input  logic          t4,
    input  logic          m1,
    input  logic          req_rd,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [DW-1:0] din,
`ifdef SM83_BUS_WAIT_EN
    input  logic          mem_ready,
    output logic          stall,
    output logic          timeout,
`endif
    output logic [AW-1:0] addr_out,
    output logic [DW-1:0] dout,
    output logic          dout_oe,
    output logic          rd_n,
    output logic          wr_n,
    output logic          fetch,
    output logic [DW-1:0] rdata,
    output logic          rdata_valid,
    output logic          proto_err
);

    bus_state_t state;
    bus_state_t state_nxt;

    logic [3:0] ph;
    logic       rd_req;
    logic       wr_req;
    logic       cap_ok;

    assign ph     = {t4, t3, t2, t1};
    assign rd_req = req_rd & ~req_wr;
    assign wr_req = req_wr & ~req_rd;

`ifdef SM83_BUS_WAIT_EN
    logic waiting;
    logic at_max;

    // A wait is pending while the access sits in t3 without mem_ready; the limit releases it.
    assign waiting = (state != IDLE) && t3 && !mem_ready;
    assign stall   = waiting && !at_max;
    assign cap_ok  = mem_ready || at_max;

    sm83_bus_wait_ctr #(
        .MAX (WAIT_MAX)
    ) u_wait_ctr (
        .clk    (clk),
        .reset  (reset),
        .clear  (!stall),
        .inc    (stall),
        .at_max (at_max)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout <= 1'b0;
        end else begin
            timeout <= waiting && at_max;
        end
    end
`else
    assign cap_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (t4) begin
            if (rd_req) begin
                state_nxt = RD;
            end else if (wr_req) begin
                state_nxt = WR;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_comb begin
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        dout_oe = 1'b0;
        if (state == RD) begin
            rd_n = !in_window(ph, RD_STB_WIN);
        end
        if (state == WR) begin
            wr_n    = !in_window(ph, WR_STB_WIN);
            dout_oe = in_window(ph, WR_OE_WIN);
        end
    end

    // Address/data latch on the t4 edge that starts an access; idle M-cycles hold the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_out    <= '0;
            dout        <= '0;
            fetch       <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            proto_err   <= t4 & req_rd & req_wr;
            if (t4) begin
                fetch <= 1'b0;
                if (rd_req || wr_req) begin
                    addr_out <= req_addr;
                    dout     <= req_wdata;
                    fetch    <= m1 & rd_req;
                end
            end
            if ((state == RD) && t3 && cap_ok) begin
                rdata       <= din;
                rdata_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sm83_bus_ctrl.sv
// Self-checking bench for sm83_bus_ctrl: per-clock reference model plus a read-data scoreboard.
module tb_sm83_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        t1 = 1'b0, t2 = 1'b0, t3 = 1'b0, t4 = 1'b0;
    logic        m1 = 1'b0;
    logic        req_rd = 1'b0, req_wr = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic [7:0]  din = '0;
    logic [15:0] addr_out;
    logic [7:0]  dout;
    logic        dout_oe, rd_n, wr_n, fetch;
    logic [7:0]  rdata;
    logic        rdata_valid, proto_err;
`ifdef SM83_BUS_WAIT_EN
    logic        mem_ready = 1'b1;
    logic        stall, timeout;
`endif

    int checks = 0;
    int failures = 0;

    // reference model: cur 0=idle 1=read 2=write
    int          cur = 0;
    logic [15:0] maddr = '0;
    logic [7:0]  mdout = '0;
    logic        mfetch = 1'b0;
    logic [7:0]  mrdata = '0;
    logic        exp_proto = 1'b0;
    logic [7:0]  sb_q[$];

    always #5 clk = ~clk;

    sm83_bus_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .t1          (t1),
        .t2          (t2),
        .t3          (t3),
        .t4          (t4),
        .m1          (m1),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .din         (din),
`ifdef SM83_BUS_WAIT_EN
        .mem_ready   (mem_ready),
        .stall       (stall),
        .timeout     (timeout),
`endif
        .addr_out    (addr_out),
        .dout        (dout),
        .dout_oe     (dout_oe),
        .rd_n        (rd_n),
        .wr_n        (wr_n),
        .fetch       (fetch),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .proto_err   (proto_err)
    );

    // One M-cycle: (rd, wr, a, wd, m1v) is the request for the next M-cycle, dv is read data at t3.
    task automatic run_mcycle(input logic rd, input logic wr, input logic [15:0] a,
                              input logic [7:0] wd, input logic m1v, input logic [7:0] dv,
                              input int rst_p);
        logic exp_rd_n, exp_wr_n, exp_oe, exp_rv;
        for (int p = 1; p <= 4; p++) begin
            t1 = (p == 1); t2 = (p == 2); t3 = (p == 3); t4 = (p == 4);
            req_rd = rd; req_wr = wr; req_addr = a; req_wdata = wd; m1 = m1v;
            din = (p == 3) ? dv : ~dv;
            reset = (p == rst_p);
            if (p == 3 && cur == 1 && !reset) sb_q.push_back(dv);
            exp_rd_n = !(cur == 1 && p <= 3);
            exp_wr_n = !(cur == 2 && (p == 2 || p == 3));
            exp_oe   = (cur == 2 && p >= 2);
            exp_rv   = (cur == 1 && p == 4);
            @(negedge clk);
            checks++; if (rd_n !== exp_rd_n) begin failures++; $display("FAIL rd_n p=%0d got %b exp %b", p, rd_n, exp_rd_n); end
            checks++; if (wr_n !== exp_wr_n) begin failures++; $display("FAIL wr_n p=%0d got %b exp %b", p, wr_n, exp_wr_n); end
            checks++; if (dout_oe !== exp_oe) begin failures++; $display("FAIL dout_oe p=%0d got %b exp %b", p, dout_oe, exp_oe); end
            checks++; if (rdata_valid !== exp_rv) begin failures++; $display("FAIL rdata_valid p=%0d got %b exp %b", p, rdata_valid, exp_rv); end
            if (exp_rv) begin
                checks++;
                if (sb_q.size() == 0) begin failures++; $display("FAIL scoreboard empty at rdata_valid"); end
                else mrdata = sb_q.pop_front();
            end
            checks++; if (rdata !== mrdata) begin failures++; $display("FAIL rdata p=%0d got %h exp %h", p, rdata, mrdata); end
            checks++; if (proto_err !== exp_proto) begin failures++; $display("FAIL proto_err p=%0d got %b exp %b", p, proto_err, exp_proto); end
            checks++; if (addr_out !== maddr) begin failures++; $display("FAIL addr_out p=%0d got %h exp %h", p, addr_out, maddr); end
            checks++; if (dout !== mdout) begin failures++; $display("FAIL dout p=%0d got %h exp %h", p, dout, mdout); end
            checks++; if (fetch !== mfetch) begin failures++; $display("FAIL fetch p=%0d got %b exp %b", p, fetch, mfetch); end
`ifdef SM83_BUS_WAIT_EN
            checks++; if (stall !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL stall/timeout p=%0d got %b/%b exp 0/0", p, stall, timeout); end
`endif
            @(posedge clk); #1;
            if (reset) begin
                cur = 0; maddr = '0; mdout = '0; mfetch = 1'b0; mrdata = '0; exp_proto = 1'b0;
            end else begin
                exp_proto = 1'b0;
                if (p == 4) begin
                    exp_proto = rd & wr;
                    cur = (rd & !wr) ? 1 : ((wr & !rd) ? 2 : 0);
                    if (cur != 0) begin
                        maddr = a; mdout = wd; mfetch = m1v & rd;
                    end else begin
                        mfetch = 1'b0;
                    end
                end
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        t1 = 0; t2 = 0; t3 = 0; t4 = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (addr_out !== 16'h0000 || dout !== 8'h00 || rdata !== 8'h00) begin
            failures++; $display("FAIL reset_data addr=%h dout=%h rdata=%h exp 0/0/0", addr_out, dout, rdata); end
        checks++; if (rd_n !== 1'b1 || wr_n !== 1'b1 || dout_oe !== 1'b0) begin
            failures++; $display("FAIL reset_strobes rd_n=%b wr_n=%b oe=%b exp 1/1/0", rd_n, wr_n, dout_oe); end
        checks++; if (fetch !== 1'b0 || rdata_valid !== 1'b0 || proto_err !== 1'b0) begin
            failures++; $display("FAIL reset_flags fetch=%b rv=%b perr=%b exp 0/0/0", fetch, rdata_valid, proto_err); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_read();
        run_mcycle(1'b1, 1'b0, 16'hC000, 8'h00, 1'b1, 8'h00, 0);
        run_mcycle(1'b0, 1'b0, 16'h5555, 8'h11, 1'b0, 8'h3E, 0);
        checks++; if (rdata !== 8'h3E) begin failures++; $display("FAIL read_data got %h exp 3E", rdata); end
    endtask

    task automatic test_write();
        run_mcycle(1'b0, 1'b1, 16'hFF80, 8'hA5, 1'b0, 8'h00, 0);
        run_mcycle(1'b0, 1'b0, 16'h0F0F, 8'h3C, 1'b0, 8'h77, 0);
        checks++; if (dout !== 8'hA5 || addr_out !== 16'hFF80) begin
            failures++; $display("FAIL write_bus got %h/%h exp FF80/A5", addr_out, dout); end
    endtask

    task automatic test_conflict();
        run_mcycle(1'b1, 1'b1, 16'h1111, 8'h22, 1'b1, 8'h00, 0);
        run_mcycle(1'b0, 1'b0, 16'h2222, 8'h33, 1'b0, 8'h44, 0);
        checks++; if (addr_out !== 16'hFF80) begin failures++; $display("FAIL conflict_addr got %h exp FF80", addr_out); end
    endtask

    task automatic test_back_to_back();
        run_mcycle(1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 8'h00, 0);
        run_mcycle(1'b0, 1'b1, 16'h4321, 8'h77, 1'b0, 8'h5A, 0);
        run_mcycle(1'b0, 1'b0, 16'hAAAA, 8'hBB, 1'b0, 8'hCC, 0);
        run_mcycle(1'b0, 1'b0, 16'hBBBB, 8'hCC, 1'b0, 8'hDD, 0);
        checks++; if (addr_out !== 16'h4321 || rdata !== 8'h5A) begin
            failures++; $display("FAIL b2b_hold addr=%h rdata=%h exp 4321/5A", addr_out, rdata); end
    endtask

    task automatic test_mid_reset();
        run_mcycle(1'b1, 1'b0, 16'h8000, 8'h00, 1'b1, 8'h00, 0);
        run_mcycle(1'b0, 1'b0, 16'h9000, 8'h00, 1'b0, 8'h99, 2);
        run_mcycle(1'b0, 1'b0, 16'h9001, 8'h00, 1'b0, 8'h98, 0);
        checks++; if (rdata !== 8'h00 || addr_out !== 16'h0000) begin
            failures++; $display("FAIL mid_reset rdata=%h addr=%h exp 00/0000", rdata, addr_out); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_mcycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                       8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 0);
        end
        run_mcycle(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 0);
        run_mcycle(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 0);
    endtask

`ifdef SM83_BUS_WAIT_EN
    task automatic set_ph(input int p);
        t1 = (p == 1); t2 = (p == 2); t3 = (p == 3); t4 = (p == 4);
        req_rd = 1'b0; req_wr = 1'b0;
    endtask

    task automatic wait_read(input logic [15:0] a, input logic [7:0] dv, input int ready_after,
                             input int exp_stalls, input logic exp_to);
        int stalls = 0;
        run_mcycle(1'b1, 1'b0, a, 8'h00, 1'b0, 8'h00, 0);
        set_ph(1); @(posedge clk); #1;
        set_ph(2); @(posedge clk); #1;
        set_ph(3); din = dv; mem_ready = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (n == ready_after) mem_ready = 1'b1;
            @(negedge clk);
            if (stall !== 1'b1) break;
            stalls++;
            @(posedge clk); #1;
        end
        checks++; if (stalls != exp_stalls) begin failures++; $display("FAIL stall_count got %0d exp %0d", stalls, exp_stalls); end
        @(posedge clk); #1;
        set_ph(4); mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (rdata_valid !== 1'b1 || rdata !== dv) begin
            failures++; $display("FAIL wait_capture rv=%b rdata=%h exp 1/%h", rdata_valid, rdata, dv); end
        checks++; if (timeout !== exp_to) begin failures++; $display("FAIL timeout got %b exp %b", timeout, exp_to); end
        @(posedge clk); #1;
        cur = 0; mrdata = dv; mfetch = 1'b0; exp_proto = 1'b0;
    endtask

    task automatic test_wait();
        wait_read(16'hA000, 8'hC3, 3, 3, 1'b0);
        wait_read(16'hB000, 8'h5D, 99, 15, 1'b1);
        run_mcycle(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_conflict();
        test_back_to_back();
        test_mid_reset();
        test_random();
`ifdef SM83_BUS_WAIT_EN
        test_wait();
`endif
        checks++;
        if (sb_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got %0d exp 0", sb_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
